// File: rtl/str_fir_pkg.sv
// str_fir_pkg: shared types, default compensation coefficients and output rounding for the CIC compensation FIR.
package str_fir_pkg;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_e;

    // h[0] occupies the low CW bits; h[L-1] is the centre tap. Taps sum to 32768, i.e. unity DC gain.
    localparam logic [4*16-1:0] COMP_COEF = {16'sd16384, 16'sd9830, 16'sd0, -16'sd1638};

    function automatic logic signed [31:0] sat_round(input logic signed [63:0] acc, input int w, input int cw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return 32'(r > hi ? hi : r < lo ? lo : r);
    endfunction

endpackage

// File: rtl/str_cic_comp_fir_if.sv
// str_cic_comp_fir_if: valid/ready sample stream between the CIC downsampler, the compensation FIR and its consumer.
interface str_cic_comp_fir_if #(parameter int W = 16);
    logic signed [W-1:0] tdata;
    logic                tvalid;
    logic                tready;

    modport master(output tdata, output tvalid, input tready);
    modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/str_fir_delay_line.sv
// str_fir_delay_line: K-entry circular sample history with two combinational read ports addressed by tap offset.
module str_fir_delay_line #(
    parameter int W = 16,
    parameter int K = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic signed [W-1:0]         i_wdata,
    input  logic        [$clog2(K)-1:0] i_off_a,
    input  logic        [$clog2(K)-1:0] i_off_b,
    output logic signed [W-1:0]         o_rd_a,
    output logic signed [W-1:0]         o_rd_b
);
    localparam int PW = $clog2(K);

    logic signed [W-1:0] r_mem [K];
    logic        [PW-1:0] r_wp;
    logic        [PW-1:0] w_addr_a;
    logic        [PW-1:0] w_addr_b;

    // Newest sample sits just behind the write pointer, so offset d maps to (wp - 1 - d) mod K.
    function automatic logic [PW-1:0] rd_addr(input logic [PW-1:0] wp, input logic [PW-1:0] off);
        logic [PW:0] t;
        t = {1'b0, wp} + (PW+1)'(K - 1) - {1'b0, off};
        return PW'(t >= (PW+1)'(K) ? t - (PW+1)'(K) : t);
    endfunction

    always_comb begin
        w_addr_a = rd_addr(r_wp, i_off_a);
        w_addr_b = rd_addr(r_wp, i_off_b);
    end

    assign o_rd_a = r_mem[w_addr_a];
    assign o_rd_b = r_mem[w_addr_b];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < K; j++) r_mem[j] <= '0;
            r_wp <= '0;
        end else if (i_we) begin
            r_mem[r_wp] <= i_wdata;
            r_wp        <= r_wp == PW'(K - 1) ? '0 : r_wp + 1'b1;
        end
    end

endmodule

// File: rtl/str_cic_comp_fir.sv
// str_cic_comp_fir: symmetric FIR compensating CIC passband droop, one output per input,
// using a single time-shared multiplier with symmetric pre-add.
module str_cic_comp_fir
    import str_fir_pkg::*;
#(
    parameter int                     W    = 16,
    parameter int                     CW   = 16,
    parameter int                     K    = 7,
    parameter logic [((K+1)/2)*CW-1:0] COEF = COMP_COEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    str_cic_comp_fir_if.slave    s_axis,
    str_cic_comp_fir_if.master   m_axis
);
    localparam int L   = (K + 1) / 2;
    localparam int IW  = $clog2(L);
    localparam int PW  = $clog2(K);
    localparam int PRW = W + 1 + CW;
    localparam int AW  = W + CW + 1 + $clog2(L);

    localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
    localparam logic [1:0] ST_MAC   = 2'(S_MAC);
    localparam logic [1:0] ST_ROUND = 2'(S_ROUND);
    localparam logic [1:0] ST_OUT   = 2'(S_OUT);

    if (K % 2 == 0 || K < 3) begin : g_bad_k
        $error("str_cic_comp_fir: K must be odd and >= 3");
    end

    logic        [1:0]    r_state;
    logic        [IW-1:0] r_idx;
    logic signed [AW-1:0] r_acc;
    logic signed [W-1:0]  r_tdata;
    logic                 r_tvalid;

    logic                 w_ish;
    logic                 w_osh;
    logic                 w_centre;
    logic        [PW-1:0] w_off_a;
    logic        [PW-1:0] w_off_b;
    logic signed [W-1:0]  w_xa;
    logic signed [W-1:0]  w_xb;
    logic signed [W:0]    w_pre;
    logic signed [CW-1:0] w_coef;
    logic signed [PRW-1:0] w_prod;
    logic signed [W-1:0]  w_y;

    assign s_axis.tready = (r_state == ST_IDLE) | ((r_state == ST_OUT) & m_axis.tready);
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;

    assign w_ish = s_axis.tvalid & s_axis.tready;
    assign w_osh = r_tvalid & m_axis.tready;

    str_fir_delay_line #(.W(W), .K(K)) u_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ish),
        .i_wdata (s_axis.tdata),
        .i_off_a (w_off_a),
        .i_off_b (w_off_b),
        .o_rd_a  (w_xa),
        .o_rd_b  (w_xb)
    );

    // Tap i pairs x[n-i] with its mirror x[n-(K-1-i)]; the centre tap has no partner.
    always_comb begin
        w_centre = r_idx == IW'(L - 1);
        w_off_a  = PW'(r_idx);
        w_off_b  = PW'(K - 1) - PW'(r_idx);
        w_coef   = COEF[int'(r_idx)*CW +: CW];
        w_pre    = w_centre ? (W+1)'(w_xa) : (W+1)'(w_xa) + (W+1)'(w_xb);
        w_prod   = w_pre * w_coef;
        w_y      = W'(sat_round(64'(r_acc), W, CW));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_acc    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    r_idx <= r_idx + 1'b1;
                    if (w_centre) r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_tdata  <= w_y;
                    r_tvalid <= 1'b1;
                    r_state  <= ST_OUT;
                end
                ST_OUT: begin
                    if (w_osh) begin
                        r_tvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: ;
            endcase
            // An accept (from IDLE, or from OUT together with the output handshake) restarts the MAC.
            if (w_ish) begin
                r_acc   <= '0;
                r_idx   <= '0;
                r_state <= ST_MAC;
            end
        end
    end

endmodule

// File: tb/tb_str_cic_comp_fir.sv
// tb_str_cic_comp_fir: scoreboard bench comparing the filter against a direct-form convolution model.
module tb_str_cic_comp_fir;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    str_cic_comp_fir_if #(.W(16)) s_axis ();
    str_cic_comp_fir_if #(.W(16)) m_axis ();

    str_cic_comp_fir dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (s_axis),
        .m_axis (m_axis)
    );

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     hf [7] = '{-1638, 0, 9830, 16384, 9830, 0, -1638};
    longint hist [$];
    int     exp_q [$];
    int     imp [7] = '{1000, 0, 0, 0, 0, 0, 0};

    always @(posedge clk) cyc++;

    function int model(input int x);
        longint acc;
        longint y;
        acc = 0;
        hist.push_front(x);
        for (int k = 0; k < 7; k++)
            if (k < hist.size()) acc += longint'(hf[k]) * hist[k];
        y = (acc + 16384) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0d expected none", m_axis.tdata);
            end else begin
                check("out", longint'(m_axis.tdata), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input int x);
        int n = 0;
        bit ok = 1'b1;
        s_axis.tdata  = 16'(x);
        s_axis.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis.tready) break;
            if (++n > 500) begin
                total++;
                bad++;
                ok = 1'b0;
                $display("FAIL accept_timeout: got no accept expected accept within 500 cycles");
                break;
            end
        end
        if (ok) exp_q.push_back(model(x));
        @(posedge clk);
        #1 s_axis.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        hist.delete();
        exp_q.delete();
    endtask

    initial begin
        int acc_t [$];
        int first_v;
        int guard;
        int x;
        bit done;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        m_axis.tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_tdata", m_axis.tdata, 0);
        check("rst_sready", s_axis.tready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (imp[i]) send(imp[i]);
        drain();

        repeat (20) send(1000);
        drain();

        send(-32768); send(0); send(32767); send(32767); send(32767); send(0); send(-32768);
        drain();
        send(32767); send(0); send(-32768); send(-32768); send(-32768); send(0); send(32767);
        drain();

        pulse_reset();
        m_axis.tready = 1'b0;
        fork
            begin
                foreach (imp[i]) send(imp[i]);
            end
            begin
                logic [15:0] held;
                repeat (12) @(negedge clk);
                held = m_axis.tdata;
                repeat (50) begin
                    @(negedge clk);
                    check("stall_sready", s_axis.tready, 0);
                    check("stall_hold", {m_axis.tvalid, m_axis.tdata}, {1'b1, held});
                end
                @(posedge clk);
                #1 m_axis.tready = 1'b1;
            end
        join
        drain();

        done = 1'b0;
        fork
            begin
                repeat (40) send(int'($urandom_range(0, 65535)) - 32768);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 m_axis.tready = $urandom_range(0, 3) != 0;
                end
                m_axis.tready = 1'b1;
            end
        join
        drain();

        first_v = -1;
        guard = 0;
        x = int'($urandom_range(0, 65535)) - 32768;
        s_axis.tdata  = 16'(x);
        s_axis.tvalid = 1'b1;
        while (acc_t.size() < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (m_axis.tvalid && first_v < 0) first_v = cyc;
            if (s_axis.tready) begin
                acc_t.push_back(cyc + 1);
                exp_q.push_back(model(x));
                @(posedge clk);
                #1;
                x = int'($urandom_range(0, 65535)) - 32768;
                s_axis.tdata = 16'(x);
            end
        end
        s_axis.tvalid = 1'b0;
        check("tp_accepts", acc_t.size(), 5);
        if (acc_t.size() == 5) begin
            check("tp_latency", first_v - acc_t[0], 5);
            for (int i = 1; i < 5; i++) check("tp_period", acc_t[i] - acc_t[i-1], 6);
        end
        drain();

        send(1234);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        hist.delete();
        exp_q.delete();
        @(negedge clk);
        check("midrst_tvalid", m_axis.tvalid, 0);
        check("midrst_sready", s_axis.tready, 1);
        @(posedge clk);
        #1;
        foreach (imp[i]) send(imp[i]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
